// File: rtl/myproject_mac_pipe.sv
// Pipelined signed multiply-accumulate. Products ride NUM_STAGE registers, are summed
// per vector (in_last delimits), then shifted, narrowed and held behind a valid/ready output.
module myproject_mac_pipe #(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 6,
  parameter int NUM_STAGE  = 2,
  parameter int ACC_WIDTH  = 28,
  parameter int SHIFT      = 0,
  parameter int dout_WIDTH = 16,
  parameter int SAT        = 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic                         in_last,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         dout_vld,
  input  logic                         dout_rdy,
  output logic                         dout_sat
);

  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam logic signed [dout_WIDTH-1:0] DMAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic signed [dout_WIDTH-1:0] DMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

  logic                  advance;
  logic                  take;
  logic signed [PW-1:0]  a_ext, b_ext, prod;

  logic [NUM_STAGE:1]    vld_pipe;
  logic [NUM_STAGE:1]    last_pipe;
  logic signed [PW-1:0]  p_pipe [1:NUM_STAGE];

  logic                  first;
  logic signed [ACC_WIDTH-1:0] acc, acc_base, p_ext, sum, r;
  logic signed [dout_WIDTH-1:0] dout_n;
  logic                  sat_n;
  logic                  lv, ll;

  // A held result that downstream refuses freezes the whole pipe.
  assign advance = !(dout_vld && !dout_rdy);
  assign in_rdy  = ap_rst_n && advance;
  assign take    = in_vld && in_rdy;

  // Operands widened first so the product keeps every bit.
  assign a_ext = PW'(din0);
  assign b_ext = PW'(din1);
  assign prod  = a_ext * b_ext;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      for (int s = 1; s <= NUM_STAGE; s++) p_pipe[s] <= '0;
    end else if (advance) begin
      vld_pipe[1]  <= take;
      last_pipe[1] <= in_last;
      p_pipe[1]    <= prod;
      for (int s = 2; s <= NUM_STAGE; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        last_pipe[s] <= last_pipe[s-1];
        p_pipe[s]    <= p_pipe[s-1];
      end
    end
  end

  assign lv       = vld_pipe[NUM_STAGE];
  assign ll       = last_pipe[NUM_STAGE];
  assign p_ext    = ACC_WIDTH'(p_pipe[NUM_STAGE]);
  assign acc_base = first ? '0 : acc;
  assign sum      = acc_base + p_ext;
  assign r        = sum >>> SHIFT;

  generate
    if (dout_WIDTH < ACC_WIDTH) begin : g_narrow
      logic [ACC_WIDTH-dout_WIDTH:0] hi;
      logic                          ovf;
      // Fits iff every bit above the output sign bit matches it.
      assign hi  = r[ACC_WIDTH-1:dout_WIDTH-1];
      assign ovf = !((&hi) || !(|hi));
      always_comb begin
        dout_n = r[dout_WIDTH-1:0];
        sat_n  = 1'b0;
        if (SAT != 0 && ovf) begin
          dout_n = r[ACC_WIDTH-1] ? DMIN : DMAX;
          sat_n  = 1'b1;
        end
      end
    end else begin : g_wide
      assign dout_n = dout_WIDTH'(r);
      assign sat_n  = 1'b0;
    end
  endgenerate

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc      <= '0;
      first    <= 1'b1;
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_sat <= 1'b0;
    end else if (advance) begin
      if (lv) begin
        if (ll) begin
          acc      <= '0;
          first    <= 1'b1;
          dout     <= dout_n;
          dout_sat <= sat_n;
        end else begin
          acc      <= sum;
          first    <= 1'b0;
        end
      end
      // Advancing with a result held means it was taken; reload or drop.
      dout_vld <= lv && ll;
    end
  end

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Bench for myproject_mac_pipe: three configurations (default, wrap, SHIFT=4) share one
// stimulus stream; a vector-sum model with a result queue scores every delivered output.
module tb_myproject_mac_pipe;

  logic gclk = 1'b0;
  logic rst_n = 1'b0;
  logic in_vld = 1'b0, in_last = 1'b0, dout_rdy = 1'b1;
  logic signed [15:0] din0 = '0;
  logic signed [5:0]  din1 = '0;

  logic rdy0, rdy1, rdy2, vld0, vld1, vld2, sat0, sat1, sat2;
  logic signed [15:0] dout0, dout1, dout2;

  always #5 gclk = ~gclk;

  myproject_mac_pipe u_dut (
    .ap_clk(gclk), .ap_rst_n(rst_n), .in_vld(in_vld), .in_rdy(rdy0), .in_last(in_last),
    .din0(din0), .din1(din1), .dout(dout0), .dout_vld(vld0), .dout_rdy(dout_rdy), .dout_sat(sat0));

  myproject_mac_pipe #(.SAT(0)) u_wrap (
    .ap_clk(gclk), .ap_rst_n(rst_n), .in_vld(in_vld), .in_rdy(rdy1), .in_last(in_last),
    .din0(din0), .din1(din1), .dout(dout1), .dout_vld(vld1), .dout_rdy(dout_rdy), .dout_sat(sat1));

  myproject_mac_pipe #(.SHIFT(4)) u_shf (
    .ap_clk(gclk), .ap_rst_n(rst_n), .in_vld(in_vld), .in_rdy(rdy2), .in_last(in_last),
    .din0(din0), .din1(din1), .dout(dout2), .dout_vld(vld2), .dout_rdy(dout_rdy), .dout_sat(sat2));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: wrap the exact sum to 28 bits, floor-shift, then clamp or keep low 16 bits.
  function automatic void ref_out(input longint sum, input int sh, input bit sat,
                                  output longint d, output longint s);
    longint m28 = 64'sd1 <<< 28;
    longint x   = sum % m28;
    longint rr;
    if (x < 0) x += m28;
    if (x >= m28 / 2) x -= m28;
    rr = x >>> sh;
    s = 0;
    if (sat) begin
      d = rr;
      if (rr > 32767)  begin d = 32767;  s = 1; end
      if (rr < -32768) begin d = -32768; s = 1; end
    end else begin
      d = rr & 64'hFFFF;
      if (d >= 32768) d -= 65536;
    end
  endfunction

  typedef struct { longint d0, d1, d2, s0, s1, s2; } obs_t;
  obs_t   got_q[$];
  longint exp_q[$];
  longint acc_m = 0;

  always @(negedge gclk) begin
    if (!rst_n) begin
      acc_m = 0;
      exp_q.delete();
      chk("in_rdy_in_reset", rdy0, 0);
    end else begin
      chk("in_rdy", rdy0, (vld0 && !dout_rdy) ? 0 : 1);
      chk("lockstep_vld", {vld1, vld2}, {vld0, vld0});
      if (vld0 && dout_rdy) begin
        obs_t o;
        o.d0 = dout0; o.d1 = dout1; o.d2 = dout2;
        o.s0 = sat0;  o.s1 = sat1;  o.s2 = sat2;
        got_q.push_back(o);
        if (exp_q.size() == 0) chk("unexpected_result", exp_q.size(), 1);
        else begin
          longint sm, d, s;
          sm = exp_q.pop_front();
          ref_out(sm, 0, 1, d, s); chk("dflt_dout", o.d0, d); chk("dflt_sat", o.s0, s);
          ref_out(sm, 0, 0, d, s); chk("wrap_dout", o.d1, d); chk("wrap_sat", o.s1, s);
          ref_out(sm, 4, 1, d, s); chk("shf_dout",  o.d2, d); chk("shf_sat",  o.s2, s);
        end
      end
      if (in_vld && rdy0) begin
        acc_m += longint'(din0) * longint'(din1);
        if (in_last) begin exp_q.push_back(acc_m); acc_m = 0; end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that took the term.
  task automatic send(input int a, input int b, input bit last);
    int t = 0;
    din0 = 16'(a); din1 = 6'(b); in_last = last; in_vld = 1'b1;
    @(negedge gclk);
    while (!rdy0 && t < 50) begin t++; @(negedge gclk); end
    if (t >= 50) chk("send_timeout", t, 0);
    @(posedge gclk); #1;
    in_vld = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int t = 0;
    while (got_q.size() < n && t < 100) begin @(negedge gclk); #1; t++; end
    chk("result_count", got_q.size(), n);
    @(posedge gclk); #1;
  endtask

  initial begin
    repeat (2) @(posedge gclk);
    @(negedge gclk);
    chk("rst_dout", dout0, 0); chk("rst_vld", vld0, 0); chk("rst_sat", sat0, 0);
    @(posedge gclk); #1 rst_n = 1'b1;
    @(negedge gclk);
    chk("rdy_after_rst", rdy0, 1);
    @(posedge gclk); #1;

    // Single term: latency and one-cycle valid
    send(1000, -7, 1);
    @(negedge gclk); chk("lat_e0_vld", vld0, 0);
    @(negedge gclk); chk("lat_e1_vld", vld0, 0);
    @(negedge gclk); chk("lat_e2_vld", vld0, 1); chk("lat_dout", dout0, -7000); chk("lat_sat", sat0, 0);
    @(negedge gclk); chk("lat_e3_vld", vld0, 0);
    @(posedge gclk); #1;

    // Corner product
    got_q.delete();
    send(-32768, -32, 1);
    wait_got(1);
    chk("corner_sat_dout", got_q[0].d0, 32767); chk("corner_sat_flag", got_q[0].s0, 1);
    chk("corner_wrap_dout", got_q[0].d1, 0);    chk("corner_wrap_flag", got_q[0].s1, 0);

    // Multi-term vector followed immediately by a single-term vector
    got_q.delete();
    send(100, 3, 0); send(-50, 5, 0); send(20, -31, 1); send(7, 2, 1);
    wait_got(2);
    chk("vec3_dout", got_q[0].d0, -570); chk("vec1_dout", got_q[1].d0, 14);

    // Back-pressure
    got_q.delete();
    dout_rdy = 1'b0;
    send(10, 10, 1); send(-4, 4, 1);
    begin
      int t = 0;
      while (!vld0 && t < 50) begin @(negedge gclk); t++; end
      chk("bp_first_vld", vld0, 1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_rdy", rdy0, 0); chk("bp_hold_dout", dout0, 100); chk("bp_hold_vld", vld0, 1);
      @(negedge gclk);
    end
    @(posedge gclk); #1 dout_rdy = 1'b1;
    wait_got(2);
    chk("bp_first", got_q[0].d0, 100); chk("bp_second", got_q[1].d0, -16);

    // Shift rounding (floor)
    got_q.delete();
    send(1000, 31, 1); send(-1000, 31, 1);
    wait_got(2);
    chk("shf_pos", got_q[0].d2, 1937); chk("shf_neg", got_q[1].d2, -1938);
    chk("noshf_pos", got_q[0].d0, 31000);

    // Reset mid-vector
    got_q.delete();
    send(5, 5, 0); send(6, 6, 0);
    rst_n = 1'b0;
    @(posedge gclk); #1 rst_n = 1'b1;
    send(2, 3, 1);
    wait_got(1);
    chk("rst_mid_dout", got_q[0].d0, 6);
    repeat (6) @(negedge gclk);
    chk("rst_mid_no_stale", got_q.size(), 1);
    @(posedge gclk); #1;

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 600; i++) begin
      in_vld   = ($urandom_range(0, 3) != 0);
      in_last  = ($urandom_range(0, 3) == 0);
      din0     = 16'($urandom);
      din1     = 6'($urandom);
      case ($urandom_range(0, 7))
        0: din0 = 16'sh8000;
        1: din0 = 16'sh7fff;
        2: din1 = 6'sh20;
        default: ;
      endcase
      dout_rdy = ($urandom_range(0, 3) != 0);
      @(posedge gclk); #1;
    end
    in_vld = 1'b0; in_last = 1'b0; dout_rdy = 1'b1;
    send(1, 1, 1);
    repeat (20) @(posedge gclk);
    chk("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/myproject_mac_pipe.md
Name: myproject_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit; next generation of the single-cycle 16s x 6s HLS multiplier primitive.
- Computes full-precision signed products and accumulates them over a variable-length vector delimited by `in_last`.
- Output is shifted, then saturated or wrapped, and delivered through a valid/ready handshake.
- Sits inside dense/conv layer datapaths of the gluon-tagger model, in place of the multiplier-plus-adder-tree pair.

Parameters:
- din0_WIDTH, 16, signed width of operand A.
- din1_WIDTH, 6, signed width of operand B (weight).
- NUM_STAGE, 2, multiplier pipeline register stages; legal range 1..4.
- ACC_WIDTH, 28, signed accumulator width; must be >= din0_WIDTH+din1_WIDTH.
- SHIFT, 0, arithmetic right shift applied to the final sum before narrowing; legal range 0..ACC_WIDTH-1.
- dout_WIDTH, 16, signed output width.
- SAT, 1, 1 = saturate on narrowing, 0 = wrap (keep low bits).

Ports:
- ap_clk, in, 1, clock; all logic on the rising edge.
- ap_rst_n, in, 1, synchronous active-low reset.
- in_vld, in, 1, operand pair valid.
- in_rdy, out, 1, unit can accept an operand pair this cycle.
- in_last, in, 1, current pair is the final term of the vector.
- din0, in, din0_WIDTH, signed operand A.
- din1, in, din1_WIDTH, signed operand B.
- dout, out, dout_WIDTH, signed result.
- dout_vld, out, 1, result valid.
- dout_rdy, in, 1, downstream accepts result.
- dout_sat, out, 1, qualified by dout_vld; 1 = saturation was applied to this result (always 0 when SAT=0).

Behaviour:
- **Reset** (ap_rst_n=0 at an edge): all pipe-stage valids=0, accumulator=0, first-term flag=1, dout=0, dout_vld=0, dout_sat=0.
  - in_rdy is 0 during the reset cycle and 1 in the cycle after reset is released.
  - Reset mid-vector discards all partial sums and in-flight terms.
- **Advance**: advance = !(dout_vld && !dout_rdy). in_rdy = advance (combinational). Transfer occurs when in_vld && in_rdy.
- **Stall**: when advance=0, every pipe register, the accumulator, first flag, dout, dout_vld and dout_sat hold their values. No input is lost or duplicated.
- **Product**: p = signed(din0) * signed(din1), full width din0_WIDTH+din1_WIDTH with no truncation, carried through NUM_STAGE registers together with valid and last.
- **Accumulate** (at the last pipe stage, on an advancing edge with stage valid=1):
  - sum = (first ? 0 : acc) + sext(p), computed in ACC_WIDTH with wrap on internal overflow.
  - last=0: acc <= sum, first <= 0.
  - last=1: acc <= 0, first <= 1, and the output register loads.
  - Bubbles (stage valid=0) leave acc and first unchanged.
- **Output load**:
  - r = sum >>> SHIFT (floor).
  - SAT=1: dout = clamp(r, -2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1); dout_sat = 1 if clamped.
  - SAT=0: dout = r[dout_WIDTH-1:0]; dout_sat = 0.
  - dout_vld <= 1.
- **Output clear**: on an advancing edge where dout_vld && dout_rdy and no new result is loaded, dout_vld <= 0. dout keeps its last value.
- **Back-to-back**: a new result may load on the same edge the previous one is accepted.
- **Latency**: a last term accepted at edge E gives dout_vld=1 after edge E+NUM_STAGE, i.e. NUM_STAGE+1 edges including E.
- **Throughput**: one term per cycle with dout_rdy held high.
- **Single-term vector** (in_last=1 on the first term) is legal. There is no zero-length vector.
- **Terms of the next vector** may enter immediately after a last term; the first flag separates the two vectors.

Test Plan:
- Defaults, single term din0=1000, din1=-7, in_last=1, dout_rdy=1 -> dout=-7000, dout_vld=1 exactly after edge E+2, dout_sat=0, then dout_vld=0 on the next edge.
- Corner product din0=-32768, din1=-32, last: SAT=1 -> dout=32767, dout_sat=1. SAT=0 -> dout=0 (1048576 mod 2^16), dout_sat=0.
- Three consecutive terms (100,3), (-50,5), (20,-31, last) -> one result dout=-570, then a second vector (7,2, last) follows immediately -> dout=14.
- Back-pressure: two vectors [(10,10, last), (-4,4, last)] with dout_rdy=0 for 5 cycles after the first dout_vld:
  - in_rdy=0 throughout; dout holds 100.
  - After dout_rdy=1, -16 follows; no loss, order preserved.
- SHIFT=4: single terms (1000,31) -> 1937 and (-1000,31) -> -1938.
- Reset mid-vector: accept (5,5) and (6,6) without last, assert ap_rst_n=0 for one cycle, then (2,3, last) -> dout=6, with no stale result emitted.
